// File: rtl/counter_modn.sv
// counter_modn
//   Modulo-MODULUS time-unit counter for the digital clock. One instance per
//   stage: seconds (60), minutes (60), hours (24 or 12).
//
//   Ports
//     CP        rising-edge clock
//     _CR       asynchronous active-low reset, loads INIT and clears pulses
//     en        count enable (previous stage carry/tc, or 1 for base stage)
//     adjust    adjust mode: normal counting suspended, adj_step moves count
//     adj_step  one-cycle step request in adjust mode
//     dir       adjust direction, 0 = up, 1 = down
//     load      synchronous preset strobe, highest priority
//     load_val  preset value (rejected when >= MODULUS)
//     count     registered binary count, always < MODULUS
//     count_bcd {tens, units} BCD of count
//     carry     one-cycle pulse on the edge count wraps MODULUS-1 -> 0
//     borrow    down-chain pulse, held low in this revision
//     tc        look-ahead terminal count for zero-skew chaining
//     load_err  one-cycle pulse on a rejected preset
module counter_modn #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 8,
  parameter int INIT    = 0
) (
  input  logic             CP,
  input  logic             _CR,
  input  logic             en,
  input  logic             adjust,
  input  logic             adj_step,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [7:0]       count_bcd,
  output logic             carry,
  output logic             borrow,
  output logic             tc,
  output logic             load_err
);

  // MODULUS itself may equal 2^WIDTH, so range checks compare against
  // MODULUS-1 (always representable) rather than MODULUS.
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(INIT);

  typedef struct packed {
    logic carry;
    logic borrow;
    logic load_err;
  } pulse_t;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  pulse_t           pls_q, pls_d;
  logic             at_max, at_zero;

  assign at_max  = (cnt_q == CNT_MAX);
  assign at_zero = (cnt_q == '0);

  // One action per edge: load > adjust step > normal count > hold.
  // Pulses default low so each is high for exactly one cycle.
  always_comb begin
    cnt_d = cnt_q;
    pls_d = '0;
    if (load) begin
      if (load_val <= CNT_MAX) cnt_d = load_val;
      else                     pls_d.load_err = 1'b1;
    end else if (adjust) begin
      // en is ignored here; adjusting never ripples into the next stage
      if (adj_step) begin
        if (!dir) cnt_d = at_max  ? '0      : cnt_q + WIDTH'(1);
        else      cnt_d = at_zero ? CNT_MAX : cnt_q - WIDTH'(1);
      end
    end else if (en) begin
      if (at_max) begin
        cnt_d       = '0;
        pls_d.carry = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      cnt_q <= CNT_INIT;
      pls_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pls_q <= pls_d;
    end
  end

  function automatic logic [7:0] to_bcd(input logic [31:0] v);
    return {4'(v / 32'd10), 4'(v % 32'd10)};
  endfunction

  assign count     = cnt_q;
  assign count_bcd = to_bcd(32'(cnt_q));
  assign carry     = pls_q.carry;
  assign borrow    = pls_q.borrow;
  assign load_err  = pls_q.load_err;
  // Look-ahead: next stage increments on the same edge this one wraps.
  assign tc        = en & ~adjust & at_max;

  a_in_range: assert property (@(posedge CP) disable iff (!_CR) cnt_q <= CNT_MAX);

endmodule

// File: tb/tb_counter_modn.sv
module tb_counter_modn;

  logic       CP = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, adjust = 1'b0, adj_step = 1'b0, dir = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'd0;

  logic [7:0] c60, bcd60, ch, bcdh;
  logic       cy60, bw60, tc60, le60, cyh, bwh, tch, leh;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  always #5 CP = ~CP;

  counter_modn #(.MODULUS(60), .WIDTH(8), .INIT(0)) u_sec (
    .CP(CP), ._CR(rst_n), .en(en), .adjust(adjust), .adj_step(adj_step),
    .dir(dir), .load(load), .load_val(load_val), .count(c60),
    .count_bcd(bcd60), .carry(cy60), .borrow(bw60), .tc(tc60), .load_err(le60)
  );

  counter_modn #(.MODULUS(24), .WIDTH(8), .INIT(0)) u_hr (
    .CP(CP), ._CR(rst_n), .en(en), .adjust(adjust), .adj_step(adj_step),
    .dir(dir), .load(load), .load_val(load_val), .count(ch),
    .count_bcd(bcdh), .carry(cyh), .borrow(bwh), .tc(tch), .load_err(leh)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m60 = 0, mh = 0;
  bit mcy60 = 0, mcyh = 0, mle60 = 0, mleh = 0;

  function automatic int nxt(input int m, input int c);
    if (load)     return (int'(load_val) < m) ? int'(load_val) : c;
    if (adjust)   return !adj_step ? c : (dir ? (c + m - 1) % m : (c + 1) % m);
    if (en)       return (c + 1) % m;
    return c;
  endfunction

  function automatic bit wraps(input int m, input int c);
    return !load && !adjust && en && (c == m - 1);
  endfunction

  function automatic int bcd(input int c);
    return (c / 10) * 16 + (c % 10);
  endfunction

  always @(posedge CP or negedge rst_n) begin
    if (!rst_n) begin
      m60 <= 0; mh <= 0; mcy60 <= 0; mcyh <= 0; mle60 <= 0; mleh <= 0;
    end else begin
      m60   <= nxt(60, m60);
      mh    <= nxt(24, mh);
      mcy60 <= wraps(60, m60);
      mcyh  <= wraps(24, mh);
      mle60 <= load && (int'(load_val) >= 60);
      mleh  <= load && (int'(load_val) >= 24);
    end
  end

  always @(negedge CP) begin
    if (chk_on) begin
      chk("sec.count", int'(c60), m60);
      chk("sec.bcd", int'(bcd60), bcd(m60));
      chk("sec.carry", int'(cy60), int'(mcy60));
      chk("sec.borrow", int'(bw60), 0);
      chk("sec.tc", int'(tc60), int'(en && !adjust && m60 == 59));
      chk("sec.load_err", int'(le60), int'(mle60));
      chk("hr.count", int'(ch), mh);
      chk("hr.bcd", int'(bcdh), bcd(mh));
      chk("hr.carry", int'(cyh), int'(mcyh));
      chk("hr.borrow", int'(bwh), 0);
      chk("hr.tc", int'(tch), int'(en && !adjust && mh == 23));
      chk("hr.load_err", int'(leh), int'(mleh));
    end
  end

  // Advance n rising edges; returns 1 time unit after a falling edge so
  // inputs change and literals are sampled away from both edges.
  task automatic clk(input int n);
    repeat (n) @(negedge CP);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    clk(2);
    chk("lit.reset_count", int'(c60), 0);
    chk("lit.reset_carry", int'(cy60), 0);

    // count to 37 then reset asynchronously mid-cycle
    rst_n = 1'b1; en = 1'b1;
    clk(37);
    chk("lit.sec_at_37", int'(c60), 37);
    chk("lit.hr_at_37", int'(ch), 13);
    rst_n = 1'b0;
    #1;
    chk("lit.async_rst_count", int'(c60), 0);
    chk("lit.async_rst_carry", int'(cy60), 0);
    chk("lit.async_rst_hr", int'(ch), 0);
    clk(1);
    rst_n = 1'b1;
    clk(1);
    chk("lit.first_after_rst", int'(c60), 1);

    // wrap at 59 -> 0
    clk(58);
    chk("lit.sec_59", int'(c60), 59);
    chk("lit.tc_59", int'(tc60), 1);
    clk(1);
    chk("lit.wrap_count", int'(c60), 0);
    chk("lit.wrap_carry", int'(cy60), 1);
    chk("lit.wrap_bcd", int'(bcd60), 8'h00);
    clk(1);
    chk("lit.carry_clear", int'(cy60), 0);
    chk("lit.after_wrap", int'(c60), 1);

    // hours stage
    en = 1'b0; load = 1'b1; load_val = 8'd23;
    clk(1);
    chk("lit.hr_load23", int'(ch), 23);
    chk("lit.hr_bcd23", int'(bcdh), 8'h23);
    load = 1'b0; en = 1'b1;
    clk(1);
    chk("lit.hr_wrap", int'(ch), 0);
    chk("lit.hr_carry", int'(cyh), 1);
    chk("lit.sec_24", int'(c60), 24);

    // adjust down from 0
    en = 1'b0; load = 1'b1; load_val = 8'd0;
    clk(1);
    load = 1'b0; adjust = 1'b1; dir = 1'b1; adj_step = 1'b1; en = 1'b1;
    clk(1);
    chk("lit.adj_down_sec", int'(c60), 59);
    chk("lit.adj_down_hr", int'(ch), 23);
    chk("lit.adj_borrow", int'(bw60), 0);
    chk("lit.adj_carry", int'(cy60), 0);
    adj_step = 1'b0;
    clk(3);
    chk("lit.adj_en_ignored", int'(c60), 59);
    chk("lit.adj_tc_low", int'(tc60), 0);

    // load range
    adjust = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b1; load_val = 8'd60;
    clk(1);
    chk("lit.bad_load_hold", int'(c60), 59);
    chk("lit.bad_load_err", int'(le60), 1);
    load_val = 8'd45;
    clk(1);
    chk("lit.good_load", int'(c60), 45);
    chk("lit.good_load_err", int'(le60), 0);
    chk("lit.hr_bad45_err", int'(leh), 1);
    chk("lit.hr_bad45_hold", int'(ch), 23);
    load = 1'b0;
    clk(1);
    chk("lit.hr_err_clear", int'(leh), 0);

    // priority: load beats en and adj_step
    load = 1'b1; load_val = 8'd59;
    clk(1);
    en = 1'b1; adjust = 1'b1; adj_step = 1'b1; load_val = 8'd10;
    clk(1);
    chk("lit.prio_count", int'(c60), 10);
    chk("lit.prio_carry", int'(cy60), 0);

    // adjust up wrap 59 -> 0 without carry
    adjust = 1'b0; adj_step = 1'b0; en = 1'b0; load_val = 8'd59;
    clk(1);
    load = 1'b0; adjust = 1'b1; adj_step = 1'b1;
    clk(1);
    chk("lit.adj_up_wrap", int'(c60), 0);
    chk("lit.adj_up_nocarry", int'(cy60), 0);

    // mixed traffic against the model
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 11) == 0);
      load_val = 8'($urandom_range(0, 70));
      adjust   = ($urandom_range(0, 4) == 0);
      adj_step = $urandom_range(0, 1) == 1;
      dir      = $urandom_range(0, 1) == 1;
      en       = ($urandom_range(0, 3) != 0);
      clk(1);
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
